// File: rtl/main_mem_responder.sv
// Line-granular main-memory model: one outstanding request, fixed response latency,
// a reset-cleared backing store, and a preload port for seeding contents.
module main_mem_responder #(
    parameter int LINES   = 16,
    parameter int LATENCY = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    input  logic [31:0]                mem_req_addr,
    input  logic                       mem_req_we,
    input  logic [255:0]               mem_req_data,
    output logic                       mem_resp_valid,
    output logic [255:0]               mem_resp_data,
    input  logic                       load_valid,
    input  logic [$clog2(LINES)-1:0]   load_idx,
    input  logic [255:0]               load_data,
    output logic                       busy,
    output logic [15:0]                req_count,
    output logic                       proto_err,
    output logic [1:0]                 state_dbg
);

    localparam int IW = $clog2(LINES);
    localparam int CW = $clog2(LATENCY + 1);

    // Handshake: a request is taken in an idle cycle with mem_req_valid high and no
    // preload strobe; the requester then holds valid, addr and we stable until it
    // sees the single-cycle mem_resp_valid pulse, and drops valid afterwards.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   lat_cnt;
    logic [31:0]     lat_addr;
    logic            lat_we;
    logic [255:0]    rd_buf;
    logic [255:0]    store [LINES];
    logic            accept;
    logic            preload;
    logic [IW-1:0]   req_idx;

    assign preload = (state == ST_IDLE) && load_valid;
    assign accept  = (state == ST_IDLE) && mem_req_valid && !load_valid;
    assign req_idx = mem_req_addr[5 +: IW];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The accept cycle itself counts toward the latency, so WAIT lasts LATENCY-1 cycles.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt <= CW'(1)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = mem_req_valid ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!mem_req_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_cnt   <= '0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            rd_buf    <= '0;
            req_count <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                lat_cnt   <= CW'(LATENCY - 1);
                lat_addr  <= mem_req_addr;
                lat_we    <= mem_req_we;
                req_count <= req_count + 16'd1;
                if (!mem_req_we) begin
                    rd_buf <= store[req_idx];
                end
            end else if (state == ST_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - CW'(1);
            end
            if (state == ST_WAIT &&
                (!mem_req_valid || mem_req_addr != lat_addr || mem_req_we != lat_we)) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Preload and request-write never collide: accept is blocked while load_valid is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                store[i] <= '0;
            end
        end else if (preload) begin
            store[load_idx] <= load_data;
        end else if (accept && mem_req_we) begin
            store[req_idx] <= mem_req_data;
        end
    end

    assign mem_resp_valid = (state == ST_RESP);
    assign mem_resp_data  = (state == ST_RESP && !lat_we) ? rd_buf : '0;
    assign busy           = (state != ST_IDLE);
    assign state_dbg      = state;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: a cycle-numbered transaction model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_main_mem_responder;

    localparam int LINES   = 16;
    localparam int LATENCY = 4;
    localparam int IW      = $clog2(LINES);

    logic            clock = 1'b0;
    logic            reset;
    logic            mem_req_valid;
    logic [31:0]     mem_req_addr;
    logic            mem_req_we;
    logic [255:0]    mem_req_data;
    logic            mem_resp_valid;
    logic [255:0]    mem_resp_data;
    logic            load_valid;
    logic [IW-1:0]   load_idx;
    logic [255:0]    load_data;
    logic            busy;
    logic [15:0]     req_count;
    logic            proto_err;
    logic [1:0]      state_dbg;

    main_mem_responder #(.LINES(LINES), .LATENCY(LATENCY)) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .load_valid     (load_valid),
        .load_idx       (load_idx),
        .load_data      (load_data),
        .busy           (busy),
        .req_count      (req_count),
        .proto_err      (proto_err),
        .state_dbg      (state_dbg)
    );

    // clock / reset block
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: a transaction is open from its accept cycle until the first
    // cycle at or after its response cycle in which valid is low.
    logic [255:0] m_store [LINES];
    bit           m_in_txn;
    int           m_resp_at;
    logic [31:0]  m_addr;
    bit           m_we;
    logic [255:0] m_data;
    logic [15:0]  m_count;
    bit           m_perr;
    int           cyc = 0;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) m_store[i] = '0;
            m_in_txn = 0;
            m_resp_at = -1;
            m_addr = '0;
            m_we = 0;
            m_data = '0;
            m_count = '0;
            m_perr = 0;
        end else if (!m_in_txn) begin
            if (load_valid) begin
                m_store[load_idx] = load_data;
            end else if (mem_req_valid) begin
                m_in_txn  = 1;
                m_resp_at = cyc + LATENCY;
                m_addr    = mem_req_addr;
                m_we      = mem_req_we;
                m_count   = m_count + 16'd1;
                if (mem_req_we) m_store[mem_req_addr[5 +: IW]] = mem_req_data;
                else            m_data = m_store[mem_req_addr[5 +: IW]];
            end
        end else begin
            if (cyc < m_resp_at && (!mem_req_valid || mem_req_addr != m_addr || mem_req_we != m_we))
                m_perr = 1;
            if (cyc >= m_resp_at && !mem_req_valid)
                m_in_txn = 0;
        end
        cyc++;
    end

    // scoreboard compare, every cycle
    always @(negedge clock) begin
        bit           e_valid;
        logic [255:0] e_data;
        e_valid = !reset && m_in_txn && (cyc == m_resp_at);
        e_data  = (e_valid && !m_we) ? m_data : '0;
        check("resp_valid", 256'(mem_resp_valid), 256'(e_valid));
        check("resp_data", mem_resp_data, e_data);
        check("busy", 256'(busy), 256'(!reset && m_in_txn));
        check("req_count", 256'(req_count), reset ? 256'd0 : 256'(m_count));
        check("proto_err", 256'(proto_err), 256'(!reset && m_perr));
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic w, input logic [255:0] d);
        mem_req_valid = v;
        mem_req_addr  = a;
        mem_req_we    = w;
        mem_req_data  = d;
    endtask

    task automatic set_load(input logic v, input logic [IW-1:0] i, input logic [255:0] d);
        load_valid = v;
        load_idx   = i;
        load_data  = d;
    endtask

    // n counts cycles from the current one (cycle 0) to the response cycle
    task automatic wait_resp(output logic [255:0] d, output int n);
        d = '0;
        n = 0;
        while (n < 30) begin
            @(negedge clock);
            if (mem_resp_valid) begin
                d = mem_resp_data;
                return;
            end
            n++;
        end
        check("resp_timeout", 256'(n), 256'(LATENCY));
    endtask

    task automatic preload(input logic [IW-1:0] i, input logic [255:0] d);
        tick();
        set_load(1'b1, i, d);
        tick();
        set_load(1'b0, '0, '0);
    endtask

    task automatic transact(input logic [31:0] a, input logic w, input logic [255:0] wd,
                            output logic [255:0] d, output int n);
        tick();
        set_req(1'b1, a, w, wd);
        wait_resp(d, n);
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        tick();
    endtask

    logic [255:0] rd;
    int           lat;
    logic [255:0] pat_a5;
    logic [255:0] pat_55;
    logic [255:0] pat_11;
    logic [255:0] pat_44;

    initial begin
        pat_a5 = {8{32'hA5A5A5A5}};
        pat_55 = {8{32'h55555555}};
        pat_11 = {8{32'h11111111}};
        pat_44 = {8{32'h44444444}};
        reset = 1'b1;
        set_req(1'b0, '0, 1'b0, '0);
        set_load(1'b0, '0, '0);
        repeat (3) tick();
        check("reset_busy", 256'(busy), 256'd0);
        check("reset_count", 256'(req_count), 256'd0);
        reset = 1'b0;
        tick();

        // preload then read line 3
        preload(4'd3, pat_a5);
        transact(32'h60, 1'b0, '0, rd, lat);
        check("rd3_latency", 256'(lat), 256'd4);
        check("rd3_data", rd, pat_a5);
        check("rd3_count", 256'(req_count), 256'd1);

        // write line 2, read it directly and through an alias
        transact(32'h40, 1'b1, 256'h1234, rd, lat);
        check("wr2_latency", 256'(lat), 256'd4);
        check("wr2_resp_data", rd, 256'd0);
        transact(32'h40, 1'b0, '0, rd, lat);
        check("rd2_data", rd, 256'h1234);
        transact(32'h240, 1'b0, '0, rd, lat);
        check("rd2_alias_data", rd, 256'h1234);

        // keep valid up for 3 cycles past the response
        tick();
        set_req(1'b1, 32'h60, 1'b0, '0);
        wait_resp(rd, lat);
        repeat (3) begin
            tick();
            check("hold_busy", 256'(busy), 256'd1);
            check("hold_no_resp", 256'(mem_resp_valid), 256'd0);
        end
        set_req(1'b0, '0, 1'b0, '0);
        tick();
        check("hold_released", 256'(busy), 256'd0);
        check("hold_count", 256'(req_count), 256'd5);

        // preload and request together: preload wins, read follows
        tick();
        set_load(1'b1, 4'd5, pat_55);
        set_req(1'b1, 32'hA0, 1'b0, '0);
        tick();
        set_load(1'b0, '0, '0);
        wait_resp(rd, lat);
        check("pri_latency", 256'(lat), 256'd4);
        check("pri_data", rd, pat_55);
        check("pri_count", 256'(req_count), 256'd6);
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        tick();

        // address changes mid-wait
        preload(4'd1, pat_11);
        preload(4'd4, pat_44);
        tick();
        set_req(1'b1, 32'h20, 1'b0, '0);
        tick();
        mem_req_addr = 32'h80;
        wait_resp(rd, lat);
        check("perr_latency", 256'(lat), 256'd3);
        check("perr_data", rd, pat_11);
        check("perr_flag", 256'(proto_err), 256'd1);
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        repeat (3) tick();
        check("perr_sticky", 256'(proto_err), 256'd1);

        // reset during a write's wait phase
        tick();
        set_req(1'b1, 32'h60, 1'b1, {8{32'hDEADBEEF}});
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_resp_valid", 256'(mem_resp_valid), 256'd0);
        check("rst_resp_data", mem_resp_data, 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_count", 256'(req_count), 256'd0);
        check("rst_perr", 256'(proto_err), 256'd0);
        set_req(1'b0, '0, 1'b0, '0);
        tick();
        tick();
        reset = 1'b0;
        set_req(1'b1, 32'h60, 1'b0, '0);
        wait_resp(rd, lat);
        check("post_rst_latency", 256'(lat), 256'd4);
        check("post_rst_data", rd, 256'd0);
        check("post_rst_count", 256'(req_count), 256'd1);
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
